mult_share_arbiter: RTL and testbench

Shares one `mult_unsigned_pipe_3stages` fixed-point multiplier between NREQ requesters. It arbitrates one operand pair per cycle into the multiplier, carrying the requester index alongside the data through a tag pipeline. It then broadcasts each product with the index of the requester that issued it. It sits between the ALU front-end issue ports and the shared multiplier instance, which it instantiates internally.

---
 rtl/mult_share_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_mult_share_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter
//   Shares one 3-stage unsigned fixed-point multiplier between NREQ
//   requesters. One operand pair per cycle is granted into the issue
//   registers. The requester index rides beside the data in a tag pipeline,
//   so each product comes out with the index of the requester that issued it.
//
// Ports
//   CLK        rising-edge clock
//   RST        synchronous active-low reset
//   req_valid  [NREQ]       per-requester request valid
//   req_ready  [NREQ]       per-requester grant (one-hot or zero), combinational
//   req_in1    [NREQ*W1]    operand 1, requester i at [i*W1 +: W1]
//   req_in2    [NREQ*W2]    operand 2, requester i at [i*W2 +: W2]
//   res_valid               single-cycle pulse per product
//   res_id     [IDW]        owner of the product
//   res_data   [WO]         product in WIO.WFO format
//   idle                    no operation in flight
//
// Configuration
//   MULT_ARB_FIXED_PRIO_EN  defined: the lowest asserted index always wins
//                           and there is no grant pointer.
//                           undefined: round-robin starting after the last grant.

// Unsigned fixed-point multiplier with three register stages and no stall:
// input register, full-product register, formatted output register.
// The output keeps the low WIO integer bits and truncates to WFO fraction bits.
module mult_unsigned_pipe_3stages #(
  parameter int WI1 = 1,
  parameter int WF1 = 23,
  parameter int WI2 = 1,
  parameter int WF2 = 23,
  parameter int WIO = 2,
  parameter int WFO = 2
) (
  input  logic                   CLK,
  input  logic [WI1+WF1-1:0]     in1,
  input  logic [WI2+WF2-1:0]     in2,
  output logic [WIO+WFO-1:0]     out
);
  localparam int W1 = WI1 + WF1;
  localparam int W2 = WI2 + WF2;
  localparam int WO = WIO + WFO;
  localparam int WP = W1 + W2;
  localparam int PW = WP + WFO;

  logic [W1-1:0] in1_q;
  logic [W2-1:0] in2_q;
  logic [WP-1:0] prod_q, prod_d;
  logic [WO-1:0] out_q, out_d;

  always_comb begin
    prod_d = WP'(in1_q) * WP'(in2_q);
    // Align the product's binary point (WF1+WF2) to the output's (WFO);
    // the cast drops integer bits above WIO.
    out_d  = WO'((PW'(prod_q) << WFO) >> (WF1 + WF2));
  end

  always_ff @(posedge CLK) begin
    in1_q  <= in1;
    in2_q  <= in2;
    prod_q <= prod_d;
    out_q  <= out_d;
  end

  assign out = out_q;
endmodule

module mult_share_arbiter #(
  parameter int NREQ = 4,
  parameter int WI1  = 1,
  parameter int WF1  = 23,
  parameter int WI2  = 1,
  parameter int WF2  = 23,
  parameter int WIO  = 2,
  parameter int WFO  = 2
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic [NREQ-1:0]                 req_valid,
  output logic [NREQ-1:0]                 req_ready,
  input  logic [NREQ*(WI1+WF1)-1:0]       req_in1,
  input  logic [NREQ*(WI2+WF2)-1:0]       req_in2,
  output logic                            res_valid,
  output logic [$clog2(NREQ)-1:0]         res_id,
  output logic [WIO+WFO-1:0]              res_data,
  output logic                            idle
);
  localparam int W1  = WI1 + WF1;
  localparam int W2  = WI2 + WF2;
  localparam int IDW = $clog2(NREQ);
  localparam int STAGES = 3;

  logic            grant_v;
  logic [IDW-1:0]  grant_id;
  logic            accept;

  logic            iss_v_q, iss_v_d;
  logic [W1-1:0]   iss_in1_q, iss_in1_d;
  logic [W2-1:0]   iss_in2_q, iss_in2_d;
  logic [IDW-1:0]  iss_id_q, iss_id_d;

  // Tag pipeline, stage STAGES lines up with the multiplier's output register.
  logic [STAGES:1]            tag_v_q, tag_v_d;
  logic [STAGES:1][IDW-1:0]   tag_id_q, tag_id_d;

`ifdef MULT_ARB_FIXED_PRIO_EN
  // Lowest asserted index wins; scanning downwards leaves the lowest last.
  always_comb begin
    grant_v  = 1'b0;
    grant_id = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        grant_v  = 1'b1;
        grant_id = IDW'(i);
      end
    end
  end
`else
  logic [IDW-1:0] ptr_q, ptr_d;

  // Search ptr+1 .. ptr+NREQ (mod NREQ); scanning offsets from far to near
  // lets the nearest valid requester after ptr overwrite the others.
  always_comb begin
    grant_v  = 1'b0;
    grant_id = '0;
    for (int off = NREQ; off >= 1; off--) begin
      if (req_valid[(int'(ptr_q) + off) % NREQ]) begin
        grant_v  = 1'b1;
        grant_id = IDW'((int'(ptr_q) + off) % NREQ);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (accept) ptr_d = grant_id;
  end

  always_ff @(posedge CLK) begin
    if (!RST) ptr_q <= IDW'(NREQ - 1);
    else      ptr_q <= ptr_d;
  end
`endif

  // No grant is offered while reset is held.
  always_comb begin
    req_ready = '0;
    if (RST && grant_v) req_ready[grant_id] = 1'b1;
  end

  assign accept = RST & grant_v;

  always_comb begin
    iss_v_d   = accept;
    iss_in1_d = iss_in1_q;
    iss_in2_d = iss_in2_q;
    iss_id_d  = iss_id_q;
    if (accept) begin
      iss_in1_d = req_in1[grant_id*W1 +: W1];
      iss_in2_d = req_in2[grant_id*W2 +: W2];
      iss_id_d  = grant_id;
    end
    tag_v_d  = {tag_v_q[STAGES-1:1], iss_v_q};
    tag_id_d = {tag_id_q[STAGES-1:1], iss_id_q};
  end

  // Clearing the valid bits drops anything in flight; the multiplier keeps
  // computing but its products are never flagged.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      iss_v_q   <= 1'b0;
      iss_in1_q <= '0;
      iss_in2_q <= '0;
      iss_id_q  <= '0;
      tag_v_q   <= '0;
      tag_id_q  <= '0;
    end else begin
      iss_v_q   <= iss_v_d;
      iss_in1_q <= iss_in1_d;
      iss_in2_q <= iss_in2_d;
      iss_id_q  <= iss_id_d;
      tag_v_q   <= tag_v_d;
      tag_id_q  <= tag_id_d;
    end
  end

  mult_unsigned_pipe_3stages #(
    .WI1(WI1), .WF1(WF1), .WI2(WI2), .WF2(WF2), .WIO(WIO), .WFO(WFO)
  ) u_mult (
    .CLK (CLK),
    .in1 (iss_in1_q),
    .in2 (iss_in2_q),
    .out (res_data)
  );

  assign res_valid = tag_v_q[STAGES];
  assign res_id    = tag_id_q[STAGES];
  assign idle      = ~iss_v_q & ~(|tag_v_q);
endmodule

// File: tb/tb_mult_share_arbiter.sv
module tb_mult_share_arbiter;
  localparam int NREQ = 4;
  localparam int WI1 = 1, WF1 = 23, WI2 = 1, WF2 = 23, WIO = 2, WFO = 2;
  localparam int W1 = WI1 + WF1, W2 = WI2 + WF2, WO = WIO + WFO;
  localparam int IDW = $clog2(NREQ);
  localparam int LAT = 4;

  logic                     CLK = 1'b0;
  logic                     RST = 1'b0;
  logic [NREQ-1:0]          req_valid = '0;
  logic [NREQ-1:0]          req_ready;
  logic [NREQ-1:0][W1-1:0]  op1 = '0;
  logic [NREQ-1:0][W2-1:0]  op2 = '0;
  logic [NREQ*W1-1:0]       req_in1;
  logic [NREQ*W2-1:0]       req_in2;
  logic                     res_valid;
  logic [IDW-1:0]           res_id;
  logic [WO-1:0]            res_data;
  logic                     idle;

  assign req_in1 = op1;
  assign req_in2 = op2;

  mult_share_arbiter #(
    .NREQ(NREQ), .WI1(WI1), .WF1(WF1), .WI2(WI2), .WF2(WF2), .WIO(WIO), .WFO(WFO)
  ) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_in1(req_in1), .req_in2(req_in2),
    .res_valid(res_valid), .res_id(res_id), .res_data(res_data),
    .idle(idle)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;
  bit mon_en = 1'b0;

  typedef struct {
    int id;
    int data;
    int acc;
  } exp_t;
  exp_t sbq[$];

  int mlast = NREQ - 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Real-number product scaled to the output grid, truncated, integer part wrapped.
  function automatic int ref_mul(input longint unsigned a, input longint unsigned b);
    longint unsigned p;
    p = a * b;
    return int'(((p << WFO) >> (WF1 + WF2)) & ((64'd1 << WO) - 1));
  endfunction

  function automatic int model_grant(input logic [NREQ-1:0] v);
`ifdef MULT_ARB_FIXED_PRIO_EN
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
`else
    for (int k = 1; k <= NREQ; k++) if (v[(mlast + k) % NREQ]) return (mlast + k) % NREQ;
`endif
    return -1;
  endfunction

  function automatic logic [W1-1:0] rnd1();
    case ($urandom_range(0, 4))
      0: return '0;
      1: return '1;
      2: return W1'(1) << WF1;
      default: return W1'($urandom);
    endcase
  endfunction

  function automatic logic [W2-1:0] rnd2();
    case ($urandom_range(0, 4))
      0: return '0;
      1: return '1;
      2: return W2'(1) << WF2;
      default: return W2'($urandom);
    endcase
  endfunction

  task automatic new_ops(input int i);
    op1[i] = rnd1();
    op2[i] = rnd2();
  endtask

  // One clock: predict the grant, check req_ready, record the expected
  // product, then advance to just after the next rising edge.
  task automatic step(output int g);
    bit rst_now;
    int c;
    exp_t keep[$];
    @(negedge CLK);
    rst_now = RST;
    c = cyc;
    g = rst_now ? model_grant(req_valid) : -1;
    check("req_ready", req_ready, (g >= 0) ? (64'd1 << g) : 64'd0);
    if (g >= 0) begin
      sbq.push_back('{g, ref_mul(op1[g], op2[g]), c});
      mlast = g;
    end
    @(posedge CLK);
    #1;
    if (!rst_now) begin
      // Anything not yet presented when reset was sampled is lost.
      mlast = NREQ - 1;
      foreach (sbq[i]) if (sbq[i].acc + LAT <= c) keep.push_back(sbq[i]);
      sbq = keep;
    end
  endtask

  // Monitor: compares DUT outputs against the scoreboard every cycle.
  always @(negedge CLK) begin : monitor
    bit exp_idle;
    if (mon_en) begin
      exp_idle = 1'b1;
      foreach (sbq[i]) if (sbq[i].acc < cyc) exp_idle = 1'b0;
      check("idle", idle, exp_idle);
      if (sbq.size() > 0 && sbq[0].acc + LAT == cyc) begin
        check("res_valid", res_valid, 1);
        check("res_id", res_id, sbq[0].id);
        check("res_data", res_data, sbq[0].data);
        void'(sbq.pop_front());
      end else begin
        check("res_valid_low", res_valid, 0);
      end
    end
  end

  int g;

  initial begin
    // Reset with every requester asserting: no grant may be offered.
    req_valid = '1;
    step(g);
    mon_en = 1'b1;
    step(g);
    step(g);
    check("rst_res_id", res_id, 0);
    RST = 1'b1;

    // 1.0 x 1.0 from requester 2.
    req_valid = '0;
    req_valid[2] = 1'b1;
    op1[2] = 24'h800000;
    op2[2] = 24'h800000;
    step(g);
    req_valid = '0;
    repeat (6) step(g);

    // 1.5 x 1.5 from requester 0.
    req_valid[0] = 1'b1;
    op1[0] = 24'hC00000;
    op2[0] = 24'hC00000;
    step(g);
    req_valid = '0;
    repeat (6) step(g);

    // Fairness from reset: all requesters held valid.
    RST = 1'b0;
    step(g);
    RST = 1'b1;
    req_valid = '1;
    for (int i = 0; i < NREQ; i++) new_ops(i);
    repeat (12) begin
      step(g);
      if (g >= 0) new_ops(g);
    end
    req_valid = '0;
    repeat (6) step(g);

    // Back-to-back from requester 1 with distinct operands.
    req_valid[1] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      op1[1] = W1'(24'h200000 * (k + 1) + k);
      op2[1] = W2'(24'hF00000 - 24'h100000 * k);
      step(g);
    end
    req_valid = '0;
    repeat (6) step(g);

    // Reset two cycles after an accept: that product must never show.
    req_valid[3] = 1'b1;
    new_ops(3);
    step(g);
    req_valid = '0;
    step(g);
    RST = 1'b0;
    step(g);
    RST = 1'b1;
    req_valid = '1;
    repeat (4) begin
      step(g);
      if (g >= 0) new_ops(g);
    end
    req_valid = '0;
    repeat (6) step(g);

    // Random traffic; requesters hold operands until granted, may drop valid.
    repeat (300) begin
      step(g);
      for (int i = 0; i < NREQ; i++) begin
        if (i == g || !req_valid[i]) begin
          req_valid[i] = ($urandom_range(0, 3) != 0);
          new_ops(i);
        end else if ($urandom_range(0, 19) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
    end
    req_valid = '0;
    repeat (8) step(g);

    check("sb_empty", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
